// File: rtl/cpu_pkg.sv
// Purpose: shared CPU constants for the EX-stage shift unit (widths, op codes, FSM encoding).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    // Shift op codes as decoded from the instruction; 2'b11 is reserved and behaves as sll.
    localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
    localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
    localparam logic [1:0] SHIFT_OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shiftState_e;

endpackage

// File: rtl/shamt_seq_shifter.sv
// Purpose: multi-cycle sll/srl/sra unit, one bit per clock, shift amount narrowed from a 32-bit source.
// Latency: done rises shamt+1 cycles after an accepted start; busy is high for exactly shamt cycles.
// Backpressure: start is ignored while busy (not queued); flush aborts to IDLE; busy drives the pipeline stall.
module shamt_seq_shifter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5   // must equal log2(DATA_W) so the largest shift is DATA_W-1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [1:0]         op,
    input  logic [DATA_W-1:0]  iData,
    input  logic [DATA_W-1:0]  iShift,
    output logic [DATA_W-1:0]  oData,
    output logic [SHAMT_W-1:0] oShamt,
    output logic               busy,
    output logic               done
);
    import cpu_pkg::*;

    shiftState_e        state;
    shiftState_e        stateNext;
    logic [DATA_W-1:0]  workReg;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         opReg;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  stepData;
    logic               accept;
    logic               lastStep;

    // Upper shift-source bits are architecturally ignored; fold them into a sink.
    logic unusedShiftHi;
    assign unusedShiftHi = ^iShift[DATA_W-1:SHAMT_W];

    assign shamt = iShift[SHAMT_W-1:0];

    // One-bit step; reserved op falls through to sll.
    function automatic logic [DATA_W-1:0] shiftOne(input logic [DATA_W-1:0] v, input logic [1:0] sop);
        case (sop)
            SHIFT_OP_SRL: shiftOne = {1'b0, v[DATA_W-1:1]};
            SHIFT_OP_SRA: shiftOne = {v[DATA_W-1], v[DATA_W-1:1]};
            default:      shiftOne = {v[DATA_W-2:0], 1'b0};
        endcase
    endfunction

    assign stepData = shiftOne(workReg, opReg);
    assign accept   = ((state == IDLE) || (state == DONE)) && start && !flush;
    assign lastStep = (state == SHIFT) && (cnt == SHAMT_W'(1)) && !flush;

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: flush dominates, DONE re-accepts a start without a bubble.
    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        stateNext = (shamt == '0) ? DONE : SHIFT;
                    end else begin
                        stateNext = IDLE;
                    end
                end
                SHIFT: begin
                    if (cnt == SHAMT_W'(1)) begin
                        stateNext = DONE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Datapath: load on accept, step while shifting; oData only updates when a result completes,
    // so a flushed or interrupted shift never exposes a partial value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            workReg <= '0;
            cnt     <= '0;
            opReg   <= SHIFT_OP_SLL;
            oData   <= '0;
            oShamt  <= '0;
        end else if (accept) begin
            workReg <= iData;
            cnt     <= shamt;
            opReg   <= op;
            oShamt  <= shamt;
            if (shamt == '0) begin
                oData <= iData;
            end
        end else if ((state == SHIFT) && !flush) begin
            workReg <= stepData;
            cnt     <= cnt - SHAMT_W'(1);
            if (lastStep) begin
                oData <= stepData;
            end
        end
    end

endmodule

// File: tb/tb_shamt_seq_shifter.sv
module tb_shamt_seq_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] iData;
    logic [31:0] iShift;
    logic [31:0] oData;
    logic [4:0]  oShamt;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    logic [31:0] lastData;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] shift;
        logic [31:0] expData;
        logic [4:0]  expShamt;
    } vec_t;

    vec_t vecs[8];

    shamt_seq_shifter #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .iData  (iData),
        .iShift (iShift),
        .oData  (oData),
        .oShamt (oShamt),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one start, then track busy cycles, done latency and oData hold until done.
    task automatic runVec(input vec_t v);
        int  cyc;
        int  busyCnt;
        bit  seenDone;
        bit  holdOk;
        @(negedge clk);
        start  = 1'b1;
        op     = v.op;
        iData  = v.data;
        iShift = v.shift;
        @(negedge clk);
        start    = 1'b0;
        iData    = 32'h5A5A_A5A5;
        iShift   = 32'h0000_0013;
        cyc      = 1;
        busyCnt  = 0;
        seenDone = 1'b0;
        holdOk   = 1'b1;
        while (cyc <= 40 && !seenDone) begin
            if (done) begin
                seenDone = 1'b1;
            end else begin
                if (busy) busyCnt++;
                if (oData !== lastData) holdOk = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        check({v.name, " latency"}, 32'(cyc), 32'(v.expShamt) + 32'd1);
        check({v.name, " busy_cycles"}, 32'(busyCnt), 32'(v.expShamt));
        check({v.name, " hold_during_shift"}, {31'd0, holdOk}, 32'd1);
        check({v.name, " oData"}, oData, v.expData);
        check({v.name, " oShamt"}, {27'd0, oShamt}, {27'd0, v.expShamt});
        @(negedge clk);
        check({v.name, " done_one_cycle"}, {31'd0, done}, 32'd0);
        lastData = v.expData;
    endtask

    initial begin
        bit sawDone;
        vecs[0] = '{"sll_narrow",   2'b00, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 5'd4};
        vecs[1] = '{"sra_max",      2'b10, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 5'd31};
        vecs[2] = '{"srl_max",      2'b01, 32'h8000_0000, 32'd31,        32'h0000_0001, 5'd31};
        vecs[3] = '{"sra_neg7",     2'b10, 32'h8123_4567, 32'd7,         32'hFF02_468A, 5'd7};
        vecs[4] = '{"sra_pos4",     2'b10, 32'h7000_0000, 32'd4,         32'h0700_0000, 5'd4};
        vecs[5] = '{"rsvd_as_sll",  2'b11, 32'h0000_0003, 32'd2,         32'h0000_000C, 5'd2};
        vecs[6] = '{"srl_16_hi",    2'b01, 32'hCAFE_0000, 32'h0000_0130, 32'h0000_CAFE, 5'd16};
        vecs[7] = '{"sll_1",        2'b00, 32'h8000_0001, 32'd1,         32'h0000_0002, 5'd1};

        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 2'b00;
        iData  = 32'h0;
        iShift = 32'h0;
        lastData = 32'h0;

        repeat (2) @(negedge clk);
        check("reset oData", oData, 32'h0);
        check("reset oShamt", {27'd0, oShamt}, 32'h0);
        check("reset busy", {31'd0, busy}, 32'h0);
        check("reset done", {31'd0, done}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runVec(vecs[i]);
        end

        // Zero shift, then back-to-back start issued in the DONE cycle.
        @(negedge clk);
        start = 1'b1; op = 2'b01; iData = 32'hDEAD_BEEF; iShift = 32'h0000_0020;
        @(negedge clk);
        check("zero done_at_1", {31'd0, done}, 32'd1);
        check("zero busy", {31'd0, busy}, 32'd0);
        check("zero oData", oData, 32'hDEAD_BEEF);
        start = 1'b1; op = 2'b00; iShift = 32'd1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy", {31'd0, busy}, 32'd1);
        check("b2b hold", oData, 32'hDEAD_BEEF);
        @(negedge clk);
        check("b2b done", {31'd0, done}, 32'd1);
        check("b2b oData", oData, 32'hBD5B_7DDE);
        @(negedge clk);
        check("b2b idle", {31'd0, done | busy}, 32'd0);

        // Start while shifting is ignored.
        start = 1'b1; op = 2'b00; iData = 32'h0000_00FF; iShift = 32'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; iData = 32'h1234_5678; iShift = 32'd3;
        @(negedge clk);
        start = 1'b0;
        sawDone = 1'b0;
        for (int c = 3; c <= 30 && !sawDone; c++) begin
            if (done) begin
                sawDone = 1'b1;
                check("ignored_start done_at_9", 32'(c), 32'd9);
            end else begin
                @(negedge clk);
            end
        end
        check("ignored_start seen_done", {31'd0, sawDone}, 32'd1);
        check("ignored_start oData", oData, 32'h0000_FF00);
        check("ignored_start oShamt", {27'd0, oShamt}, 32'd8);
        @(negedge clk);

        // Flush mid-shift: back to IDLE, no done, oData keeps the completed value.
        start = 1'b1; op = 2'b00; iData = 32'h0000_0001; iShift = 32'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("flush pre busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        sawDone = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (done || busy) sawDone = 1'b1;
            @(negedge clk);
        end
        check("flush stays_idle", {31'd0, sawDone}, 32'd0);
        check("flush oData", oData, 32'h0000_FF00);

        // Flush beats a simultaneous start.
        start = 1'b1; flush = 1'b1; op = 2'b00; iData = 32'h0000_0001; iShift = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_vs_start busy", {31'd0, busy}, 32'd0);
        check("flush_vs_start done", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);
        check("flush_vs_start oData", oData, 32'h0000_FF00);

        // Asynchronous reset in the middle of a shift.
        start = 1'b1; op = 2'b01; iData = 32'hF000_0000; iShift = 32'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("arst pre busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst busy", {31'd0, busy}, 32'd0);
        check("arst done", {31'd0, done}, 32'd0);
        check("arst oData", oData, 32'h0);
        check("arst oShamt", {27'd0, oShamt}, 32'd0);
        #1 rst = 1'b0;
        sawDone = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done || busy) sawDone = 1'b1;
        end
        check("arst idle_after", {31'd0, sawDone}, 32'd0);
        check("arst oData_after", oData, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
